// File: rtl/i2c_ball_tx_sequencer.sv
// i2c_ball_tx_sequencer: sends one 6-byte ball-state packet through the shared I2C master per accepted trigger, with NACK retry and sticky error.
module i2c_ball_tx_sequencer #(
    parameter logic [6:0] SLAVE_ADDR = 7'h3C,
    parameter int         MAX_RETRY  = 3,
    parameter int         RETRY_GAP  = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ball_send_trigger,
    input  logic [9:0] ball_y,
    input  logic [7:0] ball_vy,
    input  logic [1:0] gravity_counter,
    input  logic       is_collusion,
    input  logic       is_ball_moving_left,
    input  logic       responsing_i2c,
    input  logic       ready,
    input  logic       tx_done,
    input  logic       tx_nack,
    output logic       start,
    output logic       stop,
    output logic       i2c_en,
    output logic [7:0] tx_data,
    output logic       is_transfer,
    output logic       is_i2c_master_done,
    output logic       err_flag
);
    typedef enum logic [2:0] {IDLE, START, WAIT_RDY, SEND, WAIT_BYTE, STOP, WAIT_STOP, BACKOFF} state_t;
    typedef struct packed {
        logic [9:0] y;
        logic [7:0] vy;
        logic [1:0] grav;
        logic       coll;
    } ball_t;
    localparam int CW = RETRY_GAP > 1 ? $clog2(RETRY_GAP) : 1;

    state_t        state, state_nx;
    ball_t         pend_buf, act_buf;
    logic          pend, nack_seen, err_q;
    logic [2:0]    idx, retry;
    logic [CW-1:0] gap_cnt;
    logic          accept, launch, byte_last, stop_done, retry_ok, gap_done;
    logic [7:0]    cur_byte;

    assign accept    = ball_send_trigger && is_ball_moving_left;
    assign launch    = state == IDLE && pend && !responsing_i2c && ready;
    assign byte_last = idx == 3'd5;
    assign stop_done = state == WAIT_STOP && ready;
    assign retry_ok  = retry < 3'(MAX_RETRY);
    assign gap_done  = gap_cnt == CW'(RETRY_GAP - 1);
    assign cur_byte  = idx == 3'd0 ? {SLAVE_ADDR, 1'b0} :
                       idx == 3'd1 ? act_buf.y[7:0] :
                       idx == 3'd2 ? {6'b0, act_buf.y[9:8]} :
                       idx == 3'd3 ? act_buf.vy :
                       idx == 3'd4 ? {6'b0, act_buf.grav} : {7'b0, act_buf.coll};

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Pending buffer is latest-wins; the active buffer only changes on launch so retries resend it.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend      <= 1'b0;
            pend_buf  <= '0;
            act_buf   <= '0;
            idx       <= '0;
            retry     <= '0;
            nack_seen <= 1'b0;
            gap_cnt   <= '0;
            err_q     <= 1'b0;
        end else begin
            pend <= accept || (pend && !launch);
            if (accept) pend_buf <= {ball_y, ball_vy, gravity_counter, is_collusion};
            if (launch) begin
                act_buf <= pend_buf;
                idx     <= '0;
                retry   <= '0;
            end
            if (state == WAIT_BYTE && tx_done) begin
                nack_seen <= tx_nack;
                if (!tx_nack && !byte_last) idx <= idx + 3'd1;
            end
            if (stop_done && nack_seen) begin
                if (retry_ok) begin
                    retry <= retry + 3'd1;
                    idx   <= '0;
                end else begin
                    err_q <= 1'b1;
                end
            end
            gap_cnt <= state != BACKOFF ? '0 : gap_done ? gap_cnt : gap_cnt + CW'(1);
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:      state_nx = launch ? START : IDLE;
            START:     state_nx = ready ? WAIT_RDY : START;
            WAIT_RDY:  state_nx = ready ? SEND : WAIT_RDY;
            SEND:      state_nx = WAIT_BYTE;
            WAIT_BYTE: state_nx = !tx_done ? WAIT_BYTE : (tx_nack || byte_last) ? STOP : WAIT_RDY;
            STOP:      state_nx = ready ? WAIT_STOP : STOP;
            WAIT_STOP: state_nx = !ready ? WAIT_STOP : (nack_seen && retry_ok) ? BACKOFF : IDLE;
            BACKOFF:   state_nx = gap_done && !responsing_i2c ? START : BACKOFF;
            default:   state_nx = IDLE;
        endcase
    end

    always_comb begin
        start              = state == START && ready;
        stop               = state == STOP && ready;
        i2c_en             = state == SEND;
        tx_data            = (state == SEND || state == WAIT_BYTE) ? cur_byte : 8'h00;
        is_transfer        = state != IDLE;
        is_i2c_master_done = stop_done && !nack_seen;
        err_flag           = err_q;
    end
endmodule

// File: tb/tb_i2c_ball_tx_sequencer.sv
// tb_i2c_ball_tx_sequencer: directed stimulus against a reactive I2C master model, with a
// cycle-by-cycle scoreboard for packet bytes, command rules, retry spacing and status outputs.
module tb_i2c_ball_tx_sequencer;
    localparam int MAX_RETRY = 3;
    localparam int RETRY_GAP = 12;
    localparam int BUSY      = 4;

    typedef struct packed {
        logic [9:0] y;
        logic [7:0] vy;
        logic [1:0] g;
        logic       c;
    } snap_t;
    typedef struct {
        int    c;
        snap_t s;
    } trig_t;

    logic       clk = 1'b0, reset = 1'b1;
    logic       ball_send_trigger = 1'b0, is_collusion = 1'b0, is_ball_moving_left = 1'b0, responsing_i2c = 1'b0;
    logic [9:0] ball_y = '0;
    logic [7:0] ball_vy = '0;
    logic [1:0] gravity_counter = '0;
    logic       ready, tx_done, tx_nack;
    logic       start, stop, i2c_en, is_transfer, is_i2c_master_done, err_flag;
    logic [7:0] tx_data;

    always #5 clk = ~clk;

    i2c_ball_tx_sequencer #(.SLAVE_ADDR(7'h3C), .MAX_RETRY(MAX_RETRY), .RETRY_GAP(RETRY_GAP)) dut (
        .clk(clk), .reset(reset), .ball_send_trigger(ball_send_trigger), .ball_y(ball_y), .ball_vy(ball_vy),
        .gravity_counter(gravity_counter), .is_collusion(is_collusion), .is_ball_moving_left(is_ball_moving_left),
        .responsing_i2c(responsing_i2c), .ready(ready), .tx_done(tx_done), .tx_nack(tx_nack), .start(start),
        .stop(stop), .i2c_en(i2c_en), .tx_data(tx_data), .is_transfer(is_transfer),
        .is_i2c_master_done(is_i2c_master_done), .err_flag(err_flag)
    );

    int total = 0, bad = 0, cyc = 0;
    int n_start = 0, n_stop = 0, n_done = 0, n_end = 0, trig_cyc = 0, start_cyc = 0;
    int nack_mode = 0, att = 0;
    logic [7:0] log_q[$];
    trig_t trig_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] pkt_byte(input snap_t s, input int i);
        logic [7:0] b[6];
        b = '{8'h78, s.y[7:0], {6'b0, s.y[9:8]}, s.vy, {6'b0, s.g}, {7'b0, s.c}};
        return b[i];
    endfunction

    // Master model: accepts a command while ready, is busy BUSY cycles, then reports ACK/NACK for bytes.
    initial begin
        logic s_rst, s_cmd, s_start, s_byte, is_byte, nack_now;
        int busy, bidx;
        ready = 1'b1; tx_done = 1'b0; tx_nack = 1'b0;
        busy = 0; bidx = 0; is_byte = 1'b0; nack_now = 1'b0;
        forever begin
            @(negedge clk);
            s_rst = reset; s_start = start; s_byte = i2c_en; s_cmd = start | stop | i2c_en;
            @(posedge clk); #1;
            tx_done = 1'b0; tx_nack = 1'b0;
            if (s_rst === 1'b1) begin
                ready = 1'b1; busy = 0;
            end else if (busy > 0) begin
                busy--;
                if (busy == 0) begin
                    ready = 1'b1; tx_done = is_byte; tx_nack = is_byte && nack_now;
                end
            end else if (s_cmd === 1'b1 && ready) begin
                ready = 1'b0; busy = BUSY; is_byte = s_byte;
                if (s_start === 1'b1) begin att++; bidx = 0; end
                if (s_byte === 1'b1) begin
                    nack_now = nack_mode == 2 ? (bidx == 0) : (nack_mode == 1 && att == 1 && bidx == 3);
                    bidx++;
                end
            end
        end
    end

    // Scoreboard: a fresh START carries the latest trigger accepted two or more cycles earlier.
    initial begin
        snap_t act_s, sn;
        logic  m_busy, m_err, wait_stop, att_nack, in_byte, retry_pend, rst_d, fin, exp_done, prev_ready;
        logic [7:0] held;
        int att_bytes, retries, stop_cyc, found;
        act_s = '0; m_busy = 0; m_err = 0; wait_stop = 0; att_nack = 0; in_byte = 0; retry_pend = 0;
        rst_d = 0; prev_ready = 1; held = '0; att_bytes = 0; retries = 0; stop_cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                trig_q.delete();
                m_busy = 0; m_err = 0; wait_stop = 0; in_byte = 0; retry_pend = 0; retries = 0;
                rst_d = 1; prev_ready = 1;
            end else begin
                if (rst_d) chk("reset_outputs", {start, stop, i2c_en, tx_data, is_transfer, is_i2c_master_done, err_flag}, 0);
                rst_d = 0;
                if (ball_send_trigger && is_ball_moving_left) begin
                    sn = {ball_y, ball_vy, gravity_counter, is_collusion};
                    trig_q.push_back('{cyc, sn});
                    trig_cyc = cyc;
                end
                chk("one_cmd", 32'($countones({start, stop, i2c_en}) <= 1), 1);
                if (start || stop || i2c_en) chk("cmd_ready", 32'(ready || prev_ready), 1);
                fin = 0; exp_done = 0;
                if (start) begin
                    n_start++; start_cyc = cyc; att_bytes = 0; att_nack = 0;
                    if (retry_pend) begin
                        chk("retry_gap", cyc - stop_cyc - 1, RETRY_GAP);
                        retry_pend = 0;
                    end else begin
                        found = -1;
                        foreach (trig_q[i]) if (trig_q[i].c <= cyc - 2) found = i;
                        chk("launch_has_trigger", 32'(found >= 0), 1);
                        if (found >= 0) begin
                            act_s = trig_q[found].s;
                            repeat (found + 1) void'(trig_q.pop_front());
                        end
                        retries = 0; m_busy = 1;
                    end
                end
                if (i2c_en) begin
                    chk("byte_allowed", 32'(!att_nack && att_bytes < 6 && !in_byte), 1);
                    if (att_bytes < 6) chk("byte_value", tx_data, pkt_byte(act_s, att_bytes));
                    log_q.push_back(tx_data);
                    held = tx_data; in_byte = 1; att_bytes++;
                end else if (in_byte) begin
                    chk("tx_hold", tx_data, held);
                    if (tx_done) begin in_byte = 0; att_nack = tx_nack; end
                end
                if (stop) begin
                    chk("stop_allowed", 32'(!in_byte && (att_nack || att_bytes == 6)), 1);
                    n_stop++; wait_stop = 1;
                end else if (wait_stop && ready) begin
                    wait_stop = 0;
                    exp_done = !att_nack;
                    fin = !att_nack || retries == MAX_RETRY;
                    if (!fin) begin retries++; retry_pend = 1; stop_cyc = cyc; end
                end
                chk("done", is_i2c_master_done, exp_done);
                chk("is_transfer", is_transfer, m_busy);
                chk("err_flag", err_flag, m_err);
                if (is_i2c_master_done) n_done++;
                if (fin) begin
                    m_busy = 0; n_end++;
                    if (att_nack) m_err = 1;
                end
                prev_ready = ready;
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic trigger(input logic [9:0] y, input logic [7:0] vy, input logic [1:0] g, input logic c, input logic ml);
        ball_y = y; ball_vy = vy; gravity_counter = g; is_collusion = c; is_ball_moving_left = ml; ball_send_trigger = 1;
        tick();
        ball_send_trigger = 0; is_ball_moving_left = 0;
        ball_y = ~y; ball_vy = ~vy; gravity_counter = ~g; is_collusion = ~c;
    endtask

    task automatic wait_end(input int target, input int budget);
        for (int i = 0; i < budget && n_end < target; i++) tick();
        chk("packet_end_count", n_end, target);
    endtask

    initial begin
        logic [7:0] exp1[6];
        int s0, d0, e0, p0;
        exp1 = '{8'h78, 8'hA5, 8'h02, 8'hF3, 8'h02, 8'h01};
        tick(3); reset = 0; tick(2);

        log_q.delete(); s0 = n_start; d0 = n_done; e0 = n_end; p0 = n_stop;
        trigger(10'h2A5, 8'hF3, 2'd2, 1'b1, 1'b1);
        wait_end(e0 + 1, 500);
        chk("t1_latency", start_cyc - trig_cyc, 2);
        chk("t1_len", log_q.size(), 6);
        for (int i = 0; i < 6; i++) chk("t1_byte", log_q.size() > i ? 32'(log_q[i]) : 32'hFFFF_FFFF, exp1[i]);
        chk("t1_starts", n_start - s0, 1);
        chk("t1_stops", n_stop - p0, 1);
        chk("t1_done", n_done - d0, 1);
        chk("t1_err", err_flag, 0);

        s0 = n_start;
        trigger(10'h111, 8'h22, 2'd1, 1'b0, 1'b0);
        tick(100);
        chk("gate_not_left", n_start - s0, 0);
        responsing_i2c = 1; e0 = n_end;
        trigger(10'h155, 8'h0F, 2'd3, 1'b0, 1'b1);
        tick(50);
        chk("gate_busy_start", n_start - s0, 0);
        chk("gate_busy_xfer", is_transfer, 0);
        responsing_i2c = 0;
        wait_end(e0 + 1, 500);
        chk("gate_busy_after", n_start - s0, 1);

        nack_mode = 1; att = 0; log_q.delete(); s0 = n_start; d0 = n_done; e0 = n_end;
        trigger(10'h3C7, 8'h81, 2'd0, 1'b1, 1'b1);
        wait_end(e0 + 1, 800);
        chk("nack1_starts", n_start - s0, 2);
        chk("nack1_done", n_done - d0, 1);
        chk("nack1_len", log_q.size(), 10);
        chk("nack1_resend_y", log_q.size() > 5 ? 32'(log_q[5]) : 32'hFFFF_FFFF, 8'hC7);
        chk("nack1_err", err_flag, 0);

        nack_mode = 2; att = 0; s0 = n_start; d0 = n_done; e0 = n_end;
        trigger(10'h0F0, 8'h44, 2'd1, 1'b0, 1'b1);
        wait_end(e0 + 1, 1000);
        tick(2);
        chk("nackall_starts", n_start - s0, 4);
        chk("nackall_done", n_done - d0, 0);
        chk("nackall_err", err_flag, 1);
        chk("nackall_idle", is_transfer, 0);
        nack_mode = 0;

        log_q.delete(); s0 = n_start; e0 = n_end;
        trigger(10'h3FF, 8'h01, 2'd0, 1'b0, 1'b1);
        tick(8);
        trigger(10'd1, 8'h11, 2'd1, 1'b1, 1'b1);
        tick(5);
        trigger(10'd2, 8'h22, 2'd2, 1'b0, 1'b1);
        wait_end(e0 + 2, 1000);
        tick(40);
        chk("two_starts", n_start - s0, 2);
        chk("two_ends", n_end - e0, 2);
        chk("two_len", log_q.size(), 12);
        chk("two_y", log_q.size() > 7 ? 32'(log_q[7]) : 32'hFFFF_FFFF, 8'h02);
        chk("two_err_sticky", err_flag, 1);

        log_q.delete(); e0 = n_end;
        trigger(10'h2A5, 8'hF3, 2'd2, 1'b1, 1'b1);
        for (int i = 0; i < 200 && log_q.size() < 3; i++) tick();
        chk("rst_reach_b2", log_q.size(), 3);
        tick();
        reset = 1;
        tick();
        reset = 0;
        chk("rst_outputs_now", {start, stop, i2c_en, tx_data, is_transfer, is_i2c_master_done, err_flag}, 0);
        tick(3);
        trigger(10'h0C3, 8'h5A, 2'd3, 1'b0, 1'b1);
        wait_end(e0 + 1, 500);
        chk("rst_len", log_q.size(), 9);
        chk("rst_b0", log_q.size() > 3 ? 32'(log_q[3]) : 32'hFFFF_FFFF, 8'h78);
        chk("rst_b1", log_q.size() > 4 ? 32'(log_q[4]) : 32'hFFFF_FFFF, 8'hC3);
        chk("rst_err", err_flag, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/i2c_ball_tx_sequencer.md
Name: i2c_ball_tx_sequencer

Overview:
- Sequences the shared I2C master byte engine to send one ball-state packet to the opposite player board each time a send trigger is accepted.
- Snapshots ball state, drives start/byte/stop commands in order, and checks ACK on every byte.
- Retries on NACK, buffers one pending trigger, and holds off while the local slave is responding.
- Sits between game logic and the I2C master; fills the controller slot in front of it.

Parameters:
- SLAVE_ADDR, 7'h3C, 7-bit target address; byte0 is {SLAVE_ADDR,1'b0}.
- MAX_RETRY, 3, extra attempts after the first NACKed attempt (0..7).
- RETRY_GAP, 1000, idle clk cycles between STOP completion and the retry START (must be ≥1).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- ball_send_trigger  in  1  one-cycle request to send current ball state
- ball_y  in  10  ball vertical position
- ball_vy  in  8  ball vertical velocity
- gravity_counter  in  2  gravity phase
- is_collusion  in  1  paddle-collision flag
- is_ball_moving_left  in  1  trigger qualifier
- responsing_i2c  in  1  local slave busy; blocks a launch
- ready  in  1  master idle and able to accept a command
- tx_done  in  1  one-cycle pulse: byte plus ACK bit finished
- tx_nack  in  1  valid with tx_done; 1 = NACK received
- start  out  1  one-cycle command: generate START
- stop  out  1  one-cycle command: generate STOP
- i2c_en  out  1  one-cycle command: transmit tx_data
- tx_data  out  8  byte to transmit; stable from i2c_en until tx_done
- is_transfer  out  1  high from START issue through final STOP completion, including backoff
- is_i2c_master_done  out  1  one-cycle pulse: packet fully ACKed and STOP done
- err_flag  out  1  sticky; set when retries are exhausted; cleared only by reset

Behaviour:
- Reset:
  - All outputs 0; tx_data = 8'h00.
  - FSM = IDLE; pending and retry count cleared.
  - Reset mid-packet abandons the packet. No STOP is issued; the master is reset by the same reset.
- Trigger acceptance:
  - A trigger counts only if ball_send_trigger=1 and is_ball_moving_left=1 in the same cycle; otherwise it is ignored.
  - An accepted trigger snapshots all ball inputs into a pending buffer and sets pend=1.
  - The buffer is one deep; a newer accepted trigger overwrites it (latest wins).
- Packet layout, byte index 0..5:
  - 0: {SLAVE_ADDR,0}
  - 1: ball_y[7:0]
  - 2: {6'b0, ball_y[9:8]}
  - 3: ball_vy
  - 4: {6'b0, gravity_counter}
  - 5: {7'b0, is_collusion}
- FSM:
  - IDLE: if pend=1, responsing_i2c=0 and ready=1, move pending buffer to the active buffer, clear pend (unless a trigger is accepted the same cycle, which re-sets it), retry count=0, go START. is_transfer rises on the cycle after the launch condition holds.
  - START: pulse start for 1 cycle; go WAIT_RDY.
  - WAIT_RDY: wait for ready=1; then go SEND.
  - SEND: drive tx_data = byte[idx]; pulse i2c_en for 1 cycle; go WAIT_BYTE.
  - WAIT_BYTE, on tx_done:
    - tx_nack=1: go STOP with nack_seen=1.
    - tx_nack=0 and idx<5: idx++, go WAIT_RDY.
    - tx_nack=0 and idx=5: go STOP with nack_seen=0.
  - STOP: wait for ready=1; pulse stop for 1 cycle; go WAIT_STOP.
  - WAIT_STOP, on ready=1:
    - nack_seen=0: pulse is_i2c_master_done, go IDLE.
    - nack_seen=1 and retry<MAX_RETRY: retry++, idx=0, go BACKOFF.
    - otherwise: set err_flag, go IDLE. Packet dropped; no done pulse.
  - BACKOFF: count RETRY_GAP cycles; then go START if responsing_i2c=0, else hold in BACKOFF until it deasserts.
  - is_transfer is cleared on the IDLE entry cycle.
- Command rules:
  - At most one of start/stop/i2c_en is high in any cycle.
  - Each is issued only when ready=1 was sampled in the same or the previous cycle.
- Simultaneous events:
  - A trigger during a busy packet only loads pending; the active buffer is untouched. The retry resends the active buffer, not the pending one.
  - tx_done outside WAIT_BYTE is ignored.
  - A trigger and a launch in the same cycle: the launch takes the old pending data and the new trigger becomes pending.
- Latency:
  - Trigger accepted in cycle T with the master idle: start pulses at T+2 (pend set at T+1, launch at T+1, START state at T+2).

Test Plan:
- Single packet: ball_y=10'h2A5, vy=8'hF3, grav=2, coll=1, moving_left=1, all ACK -> bytes 0x78,0xA5,0x02,0xF3,0x02,0x01; one stop; one is_i2c_master_done; err_flag=0.
- Gating: trigger with is_ball_moving_left=0 -> no start for 100 cycles. Trigger with responsing_i2c=1 held 50 cycles -> start only after deassert.
- NACK on byte 3, first attempt only -> stop, RETRY_GAP idle cycles, full 6-byte resend with the original snapshot, then done pulse.
- NACK on every attempt with MAX_RETRY=3 -> exactly 4 STARTs, err_flag=1 sticky, no done pulse, FSM back in IDLE.
- Two triggers during an active packet (ball_y=1 then ball_y=2) -> after the first packet's done, exactly one more packet, carrying ball_y=2.
- Reset asserted mid byte 2 -> next cycle all outputs 0; the next accepted trigger sends a clean packet from byte 0.
